// File: rtl/seq_det_pkg.sv
// Purpose: shared types and constants for the sequence-detect job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_det_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pattern length and the pattern loaded by reset.
    localparam int              PLEN    = 5;
    localparam logic [PLEN-1:0] PAT_RST = 5'b10010;

    // Width of the per-job match counter; the count saturates at all-ones.
    localparam int HIT_W = 4;

    function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v,
                                                 input logic             inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Purpose: bit-serial overlapping pattern matcher (window of the last PLEN-1 bits).
// Latency: hit is combinational on the bit presented with bit_vld.
// Backpressure: none; consumes one bit per cycle when bit_vld is high.
//
// Ports: clk/rst_n clock and async active-low reset; clear empties the window
// (synchronous); bit_in/bit_vld serial input; pattern compared against the
// newest PLEN bits; hit flags a match ending on the current bit.
module seq_match_core #(
    parameter int PLEN = seq_det_pkg::PLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            bit_in,
    input  logic            bit_vld,
    input  logic [PLEN-1:0] pattern,
    output logic            hit
);

    localparam int FW = (PLEN > 2) ? $clog2(PLEN) : 1;

    logic [PLEN-2:0] win_q, win_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [PLEN-1:0] cand;
    logic            full;

    // A match needs PLEN real bits; fill tracks how many have arrived since
    // clear so the zeroed window never produces phantom hits (e.g. pattern 0).
    assign cand = {win_q, bit_in};
    assign full = (fill_q == FW'(PLEN - 1));
    assign hit  = bit_vld && full && (cand == pattern);

    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (clear) begin
            win_d  = '0;
            fill_d = '0;
        end else if (bit_vld) begin
            win_d = cand[PLEN-2:0];
            if (!full) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Purpose: round-robin job scheduler that scans one requester word per job for a bit pattern.
// Latency: done pulses DW+1 cycles after the accepting edge; one job per DW+2 cycles.
// Backpressure: req is a level held until gnt; other requesters wait for a later arbitration.
//
// Ports: clk, rst_n (async active-low); req[NREQ] job requests; data[NREQ*DW]
// packed words (requester i at data[i*DW +: DW]); pat_we/pat_wdata pattern
// update (IDLE only); gnt one-hot owner for the whole scan; done one-cycle
// completion pulse with done_id/hit_cnt held until the next completion.
// Option macro SEQ_DET_ABORT_EN: owner dropping req mid-scan aborts the job.
module seq_det_sched #(
    parameter int              NREQ    = 4,
    parameter int              DW      = 16,
    parameter int              PLEN    = seq_det_pkg::PLEN,
    parameter logic [PLEN-1:0] PAT_RST = seq_det_pkg::PAT_RST,
    // Derived index width; leave at default.
    parameter int              IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ*DW-1:0]             data,
    input  logic                           pat_we,
    input  logic [PLEN-1:0]                pat_wdata,
    output logic [NREQ-1:0]                gnt,
    output logic                           done,
    output logic [IW-1:0]                  done_id,
    output logic [seq_det_pkg::HIT_W-1:0]  hit_cnt
);

    import seq_det_pkg::*;

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    state_e            state_q, state_d;
    logic [DW-1:0]     sh_q, sh_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [PLEN-1:0]   pat_q, pat_d;
    logic [HIT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic [HIT_W-1:0]  hit_cnt_q, hit_cnt_d;

    logic              any_req;
    logic              found;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     win_id;
    logic [IW-1:0]     win_nxt;
    logic              m_clear;
    logic              m_vld;
    logic              m_hit;

    // Round-robin search starting at ptr_q, wrapping at NREQ.
    always_comb begin
        any_req = |req;
        found   = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
        win_nxt = (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bcnt_d    = bcnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        done_id_d = done_id_q;
        hit_cnt_d = hit_cnt_q;
        m_clear   = 1'b0;
        m_vld     = 1'b0;
        case (state_q)
            IDLE: begin
                // Pattern lands in pat_q on the accepting edge, so a job
                // accepted together with a write already scans with it.
                if (pat_we) begin
                    pat_d = pat_wdata;
                end
                if (any_req) begin
                    sh_d    = data[win_id*DW +: DW];
                    owner_d = win_id;
                    ptr_d   = win_nxt;
                    bcnt_d  = '0;
                    cnt_d   = '0;
                    m_clear = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                m_vld  = 1'b1;
                sh_d   = {sh_q[DW-2:0], 1'b0};
                bcnt_d = bcnt_q + 1'b1;
                cnt_d  = sat_inc(cnt_q, m_hit);
                if (bcnt_q == BW'(DW - 1)) begin
                    state_d   = DONE;
                    done_id_d = owner_q;
                    hit_cnt_d = cnt_d;
                end
`ifdef SEQ_DET_ABORT_EN
                // Abort wins even on the last bit: no result is published.
                if (!req[owner_q]) begin
                    state_d   = IDLE;
                    done_id_d = done_id_q;
                    hit_cnt_d = hit_cnt_q;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bcnt_q    <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            pat_q     <= PAT_RST;
            cnt_q     <= '0;
            done_id_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bcnt_q    <= bcnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            done_id_q <= done_id_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Word is fed MSB first out of the top of the shift register.
    seq_match_core #(
        .PLEN (PLEN)
    ) u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (m_clear),
        .bit_in  (sh_q[DW-1]),
        .bit_vld (m_vld),
        .pattern (pat_q),
        .hit     (m_hit)
    );

    assign gnt     = (state_q == SCAN) ? (NREQ'(1) << owner_q) : '0;
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    assign hit_cnt = hit_cnt_q;

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter DW, default 16: word width scanned per job.
REQ-003 Parameter PLEN, default 5: pattern length in bits.
REQ-004 Parameter PAT_RST, default 5'b10010: pattern value after reset.
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1: reset, asynchronous and active-low.
REQ-007 req  input  NREQ: per-requester job request, level, held until gnt.
REQ-008 data  input  NREQ*DW: packed words, requester i in data[i*DW +: DW].
REQ-009 pat_we  input  1: pattern write strobe.
REQ-010 pat_wdata  input  PLEN: new pattern value.
REQ-011 gnt  output  NREQ: one-hot grant, high for the whole job.
REQ-012 done  output  1: one-cycle job-complete pulse.
REQ-013 done_id  output  clog2(NREQ): index of the completed requester.
REQ-014 hit_cnt  output  4: match count of the completed job.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-016 IDLE with any req high: latch the winner's word into the shift register, set its gnt bit and go to SCAN on the same edge.
REQ-017 The arbiter SHALL be round-robin, searching from (last winner + 1) mod NREQ; after reset the search starts at index 0.
REQ-018 SCAN SHALL last exactly DW cycles and feed one bit per cycle to the matcher, MSB first.
REQ-019 The matcher window SHALL be cleared at job start; no matches span jobs.
REQ-020 Overlapping matches SHALL count (e.g. 10010010 = 2 hits).
REQ-021 The job counter SHALL saturate at 15.
REQ-022 After SCAN comes DONE for one cycle: done=1, gnt=0, done_id and hit_cnt updated; then IDLE.
REQ-023 done_id and hit_cnt SHALL hold their values until the next done.
REQ-024 Latency from the accepting edge to done high SHALL be DW+1 cycles; back-to-back throughput SHALL be one job per DW+2 cycles.
REQ-025 pat_we SHALL take effect only in IDLE and be ignored in SCAN and DONE.
REQ-026 When pat_we and req are both accepted in the same IDLE cycle, the new pattern SHALL apply to that job.
REQ-027 req changes of non-owners during a job SHALL have no effect; they are served on a later arbitration.

Reset
REQ-028 While rst_n=0: state=IDLE, gnt=0, done=0, done_id=0, hit_cnt=0, pattern=PAT_RST, RR pointer=0.
REQ-029 Reset mid-job SHALL discard the job with no done pulse.

Configuration
REQ-030 Macro SEQ_DET_ABORT_EN defined: the owner dropping req during SCAN SHALL return the FSM to IDLE next edge, with gnt cleared, no done, hit_cnt unchanged, and the RR pointer advanced past the owner.
REQ-031 Macro SEQ_DET_ABORT_EN undefined: a started job SHALL always complete regardless of req.

Structure
REQ-032 A shared package seq_det_pkg SHALL hold the state enum, PLEN, PAT_RST and the hit-counter width.
REQ-033 The bit-serial overlapping matcher (clear, bit_in, bit_vld, pattern, hit) SHALL be sub-module seq_match_core; arbiter and FSM stay in seq_det_sched.

Verification
REQ-034 Single request: req=4'b0001, data[15:0]=16'h9200 -> gnt=0001 for 16 cycles; done at cycle 17; done_id=0; hit_cnt=2.
REQ-035 Request on req[2] with data=16'h9249 -> hit_cnt=4; with data=16'h0000 -> hit_cnt=0.
REQ-036 Fairness: req=4'b1111 held, then each req dropped after its done -> grant order 0,1,2,3, with done 18 cycles apart.
REQ-037 Pattern write: pat_we=1, pat_wdata=5'b11111 in IDLE with req[1]=1, data=16'hFFFF -> hit_cnt=12; pat_we pulsed during SCAN -> pattern unchanged.
REQ-038 Robustness: rst_n low at SCAN cycle 8 -> gnt=0 and done never pulses. With SEQ_DET_ABORT_EN, owner req dropped at SCAN cycle 5 -> gnt=0 next cycle, no done, next requester served.
